// File: rtl/ls_bram_pkg.sv
// Shared types and helpers for the pipelined BRAM load/store sub-unit.
// It holds the load funct3 codes, the per-load metadata record and the sub-word extraction function.
package ls_bram_pkg;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;

  localparam int META_W = 5;

  typedef struct packed {
    logic [2:0] fn3;
    logic [1:0] byte_off;
  } load_meta_t;

  // Align the addressed byte or half to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input load_meta_t meta);
    logic [31:0] shifted;
    shifted = word >> {meta.byte_off, 3'b000};
    case (meta.fn3)
      FN3_LB:  extract_load = 32'($signed(shifted[7:0]));
      FN3_LH:  extract_load = 32'($signed(shifted[15:0]));
      FN3_LBU: extract_load = {24'h0, shifted[7:0]};
      FN3_LHU: extract_load = {16'h0, shifted[15:0]};
      default: extract_load = word;
    endcase
  endfunction

endpackage

// File: rtl/ls_bram_resp_fifo.sv
// First-word-fall-through response FIFO. When it is empty, dout shows din directly.
// A push that is popped in the same cycle while the FIFO is empty is never stored.
module ls_bram_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             wr;
  logic             rd;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    next_ptr = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign dout  = empty ? din : mem[rd_ptr];
  assign rd    = pop & ~empty;
  assign wr    = push & ~(empty & pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= next_ptr(wr_ptr);
      if (rd) rd_ptr <= next_ptr(rd_ptr);
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A write into the slot being popped while full is safe, because dout was read this cycle.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ls_bram_pipe.sv
// Pipelined BRAM load/store sub-unit: credit-gated loads, a latency shift register and an FWFT response FIFO.
// Defining LS_BRAM_SUBWORD_EN enables sub-word load extraction (requires DATA_W=32).
module ls_bram_pipe import ls_bram_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BRAM_LATENCY = 1,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_load,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [2:0]          req_fn3,
  output logic                rsp_valid,
  input  logic                rsp_ack,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-3:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  input  logic [DATA_W-1:0]   bram_rdata
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [CW-1:0]           credit;
  logic                    accept;
  logic                    load_acc;
  logic                    pop;
  logic                    ret_vld;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [BRAM_LATENCY-1:0] vld_p;

  assign req_ready  = (credit < CW'(RESP_DEPTH));
  assign accept     = req_valid & req_ready;
  assign load_acc   = accept & req_load;
  assign bram_en    = accept;
  assign bram_we    = (accept & ~req_load) ? req_be : '0;
  assign bram_addr  = req_addr[ADDR_W-1:2];
  assign bram_wdata = req_wdata;
  assign ret_vld    = vld_p[BRAM_LATENCY-1];
  assign rsp_valid  = ret_vld | ~fifo_empty;
  assign pop        = rsp_valid & rsp_ack;

  // Stage boundary: request accept -> BRAM return, BRAM_LATENCY cycles deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
      vld_p  <= '0;
    end else begin
      vld_p[0] <= load_acc;
      for (int i = 1; i < BRAM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      case ({load_acc, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

`ifdef LS_BRAM_SUBWORD_EN
  load_meta_t                 meta_p [BRAM_LATENCY];
  load_meta_t                 head_meta;
  logic [DATA_W+META_W-1:0]   fifo_din;
  logic [DATA_W+META_W-1:0]   fifo_dout;
  logic                       unused_ok;

  always_ff @(posedge clk) begin
    meta_p[0] <= {req_fn3, req_addr[1:0]};
    for (int i = 1; i < BRAM_LATENCY; i++) meta_p[i] <= meta_p[i-1];
  end

  assign fifo_din  = {meta_p[BRAM_LATENCY-1], bram_rdata};
  assign head_meta = fifo_dout[DATA_W +: META_W];
  assign rsp_data  = extract_load(fifo_dout[DATA_W-1:0], head_meta);
  assign unused_ok = fifo_full;
`else
  logic [DATA_W-1:0] fifo_din;
  logic [DATA_W-1:0] fifo_dout;
  logic              unused_ok;

  assign fifo_din  = bram_rdata;
  assign rsp_data  = fifo_dout;
  assign unused_ok = ^{fifo_full, req_fn3, req_addr[1:0]};
`endif

  // Stage boundary: BRAM return -> response FIFO head.
  ls_bram_resp_fifo #(
    .WIDTH ($bits(fifo_din)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_vld),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ls_bram_pipe.sv
// Directed bench for ls_bram_pipe (BRAM_LATENCY=2, RESP_DEPTH=4) with an in-order response scoreboard.
// Expected sub-word results follow LS_BRAM_SUBWORD_EN when it is defined.
module tb_ls_bram_pipe;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_load;
  logic [3:0]        req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_fn3;
  logic              rsp_valid;
  logic              rsp_ack;
  logic [DATA_W-1:0] rsp_data;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-3:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  always #5 clk = ~clk;

  ls_bram_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_LATENCY(LAT), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_load(req_load),
    .req_be(req_be), .req_wdata(req_wdata), .req_fn3(req_fn3),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM model with a two-cycle read latency
  logic [31:0] mem [64];
  logic [31:0] rd_p1;
  logic [31:0] rd_p2;
  logic        load_init;

  function automatic logic [31:0] init_word(input int i);
    if (i == 8) return 32'h1122_3344;
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[5:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
    end
    rd_p1 <= mem[bram_addr[5:0]];
    rd_p2 <= rd_p1;
  end
  assign bram_rdata = rd_p2;

  int          total = 0;
  int          bad   = 0;
  int          n_acc;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] ref_mem [64];
  logic [31:0] exp6 [3];
  logic        s_valid, s_ready, s_en, s_acc;
  logic [3:0]  s_we;
  logic [31:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] fn3,
                                            input logic [1:0] off);
    logic [7:0]  by;
    logic [15:0] hw;
    by = w[{off, 3'b000} +: 8];
    hw = off[1] ? w[31:16] : w[15:0];
`ifdef LS_BRAM_SUBWORD_EN
    case (fn3)
      3'b000:  return {{24{by[7]}}, by};
      3'b100:  return {24'h0, by};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b101:  return {16'h0, hw};
      default: return w;
    endcase
`else
    if (fn3 == 3'b111 && by == 8'h0 && hw == 16'h0) return w;
    return w;
`endif
  endfunction

  // One cycle: sample at negedge, score responses, record accepted requests, move past posedge.
  task automatic tick();
    @(negedge clk);
    s_valid = rsp_valid;
    s_ready = req_ready;
    s_en    = bram_en;
    s_we    = bram_we;
    s_data  = rsp_data;
    s_acc   = req_valid & req_ready;
    if (exp_q.size() == 0) chk1("no_rsp", rsp_valid, 1'b0);
    else if (rsp_valid && rsp_ack) begin
      chk("rsp_data", rsp_data, exp_q.pop_front());
      got_q.push_back(rsp_data);
    end
    if (s_acc) begin
      if (req_load) exp_q.push_back(ref_load(ref_mem[req_addr[7:2]], req_fn3, req_addr[1:0]));
      else
        for (int b = 0; b < 4; b++)
          if (req_be[b]) ref_mem[req_addr[7:2]][8*b +: 8] = req_wdata[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ack   = 1'b1;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; load_init = 1'b1;
    req_valid = 1'b0; req_load = 1'b1; req_addr = '0; req_be = '0; req_wdata = '0;
    req_fn3 = 3'b010; rsp_ack = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    @(posedge clk); #1;
    load_init = 1'b0;
    @(negedge clk);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_req_ready", req_ready, 1'b1);
    chk1("reset_bram_en", bram_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back loads with two-cycle latency
    rsp_ack = 1'b1; req_valid = 1'b1; req_load = 1'b1; req_addr = 32'h10;
    tick(); chk1("t1_accept0", s_acc, 1'b1);
    req_addr = 32'h14;
    tick(); chk1("t1_valid_t1", s_valid, 1'b0);
    req_valid = 1'b0;
    tick(); chk1("t1_valid_t2", s_valid, 1'b1); chk("t1_data_t2", s_data, init_word(4));
    tick(); chk1("t1_valid_t3", s_valid, 1'b1); chk("t1_data_t3", s_data, init_word(5));
    tick(); chk1("t1_valid_t4", s_valid, 1'b0);

    // credit limit under backpressure
    rsp_ack = 1'b0; req_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'h40 + 32'(4 * n_acc);
      tick();
      if (s_acc) n_acc++;
    end
    chk("t2_accepted", 32'(n_acc), 32'd4);
    chk1("t2_ready_low", s_ready, 1'b0);
    req_valid = 1'b0; rsp_ack = 1'b1;
    tick(); chk1("t2_ready_ack_cycle", s_ready, 1'b0);
    rsp_ack = 1'b0;
    tick(); chk1("t2_ready_after_ack", s_ready, 1'b1);
    drain();

    // partial store then read-back
    req_valid = 1'b1; req_load = 1'b0; req_addr = 32'h20; req_be = 4'b0011;
    req_wdata = 32'hAABB_CCDD; rsp_ack = 1'b1;
    tick();
    chk1("t3_en", s_en, 1'b1);
    chk("t3_we", {28'h0, s_we}, 32'h3);
    chk1("t3_no_rsp", s_valid, 1'b0);
    got_q.delete();
    req_load = 1'b1; req_be = 4'b0000;
    tick();
    drain();
    chk("t3_merge", got_q[0], 32'h1122_CCDD);

    // full FIFO, then streaming with simultaneous push and pop
    rsp_ack = 1'b0; req_valid = 1'b1; req_load = 1'b1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'h80 + 32'(4 * n_acc);
      tick();
      if (s_acc) n_acc++;
    end
    rsp_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_valid = (n_acc < 14);
      req_addr  = 32'h80 + 32'(4 * n_acc);
      tick();
      if (s_acc) n_acc++;
      if (i == 0) chk1("t4_ready_full", s_ready, 1'b0);
      else if (i < 10) chk1("t4_ready_steady", s_ready, 1'b1);
    end
    drain();
    chk("t4_total_loads", 32'(n_acc), 32'd14);

    // reset with loads in flight
    rsp_ack = 1'b0; req_valid = 1'b1; req_addr = 32'h30;
    tick();
    req_addr = 32'h34;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("t5_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("t5_rst_req_ready", req_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; rsp_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // sub-word loads
    req_valid = 1'b1; req_load = 1'b0; req_addr = 32'h20; req_be = 4'hF;
    req_wdata = 32'h80FF_0000;
    tick();
    got_q.delete();
    req_load = 1'b1; req_be = 4'h0; req_addr = 32'h23; req_fn3 = 3'b000;
    tick();
    req_fn3 = 3'b100;
    tick();
    req_addr = 32'h22; req_fn3 = 3'b001;
    tick();
    req_fn3 = 3'b010;
    drain();
`ifdef LS_BRAM_SUBWORD_EN
    exp6[0] = 32'hFFFF_FF80; exp6[1] = 32'h0000_0080; exp6[2] = 32'hFFFF_80FF;
`else
    exp6[0] = 32'h80FF_0000; exp6[1] = 32'h80FF_0000; exp6[2] = 32'h80FF_0000;
`endif
    for (int i = 0; i < 3; i++) chk("t6_subword", got_q[i], exp6[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
